// File: rtl/fir_stream_pkg.sv
// Shared constants and the output FIFO entry type for the FIR output stage.
package fir_stream_pkg;

  localparam int P_DATA_WIDTH = 32;
  localparam int P_OUT_WIDTH  = 16;
  localparam int P_WORD_WIDTH = 2 * P_OUT_WIDTH;

  localparam logic signed [P_OUT_WIDTH-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [P_OUT_WIDTH-1:0] SAT_MIN = 16'sh8000;

  localparam logic [3:0] KEEP_FULL = 4'hF;
  localparam logic [3:0] KEEP_LOW  = 4'h3;

  typedef struct packed {
    logic                    last;
    logic [3:0]              keep;
    logic [P_WORD_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/fir_out_fifo.sv
// Small synchronous FIFO of packed output words with a registered occupancy count.
module fir_out_fifo
  import fir_stream_pkg::*;
#(
  parameter int pDEPTH = 2,
  parameter int pCNT_W = $clog2(pDEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_push,
  input  fifo_entry_t       i_wdata,
  input  logic              i_pop,
  output fifo_entry_t       o_head,
  output logic [pCNT_W-1:0] o_count
);

  localparam int PW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

  fifo_entry_t       r_mem [pDEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [pCNT_W-1:0] r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(pDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != pCNT_W'(pDEPTH)) || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + pCNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - pCNT_W'(1);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fir_out_pack.sv
// Requantises 32-bit FIR results to 16 bits and packs sample pairs into
// 32-bit AXI-Stream words, keeping frame boundaries and saturation statistics.
module fir_out_pack
  import fir_stream_pkg::*;
#(
  parameter int pDATA_WIDTH = P_DATA_WIDTH,
  parameter int pOUT_WIDTH  = P_OUT_WIDTH,
  parameter int pFIFO_DEPTH = 2
) (
  input  logic                    axis_clk,
  input  logic                    axis_rst,
  input  logic                    s_tvalid,
  input  logic [pDATA_WIDTH-1:0]  s_tdata,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    m_tvalid,
  output logic [2*pOUT_WIDTH-1:0] m_tdata,
  output logic [3:0]              m_tkeep,
  output logic                    m_tlast,
  input  logic                    m_tready,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_round_en,
  input  logic                    sat_clr,
  output logic [15:0]             sat_cnt,
  output logic [15:0]             frame_cnt,
  output logic                    busy
);

  localparam int CNT_W = $clog2(pFIFO_DEPTH + 1);
  localparam int TW    = pDATA_WIDTH + 1;
  localparam logic signed [TW-1:0] L_MAX = TW'(SAT_MAX);
  localparam logic signed [TW-1:0] L_MIN = TW'(SAT_MIN);

  logic                  r_rdy_en;
  logic                  r_frame_open;
  logic [4:0]            r_shift;
  logic                  r_round_en;
  logic                  r_half;
  logic [pOUT_WIDTH-1:0] r_low;
  logic [15:0]           r_sat_cnt;
  logic [15:0]           r_frame_cnt;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [4:0]            w_shift;
  logic                  w_round;
  logic signed [TW-1:0]  w_x;
  logic signed [TW-1:0]  w_rnd;
  logic signed [TW-1:0]  w_t;
  logic signed [TW-1:0]  w_y;
  logic                  w_hi;
  logic                  w_lo;
  logic                  w_clip;
  logic [pOUT_WIDTH-1:0] w_q;
  fifo_entry_t           w_entry;
  fifo_entry_t           w_head;
  logic [CNT_W-1:0]      w_fifo_count;

  // r_rdy_en keeps s_tready low while in reset without touching m_tready.
  assign s_tready = r_rdy_en && (w_fifo_count < CNT_W'(pFIFO_DEPTH));
  assign w_accept = s_tvalid && s_tready;
  assign w_pop    = m_tvalid && m_tready;

  // The first beat of a frame uses the live config; later beats the latched one.
  assign w_shift = r_frame_open ? r_shift    : cfg_shift;
  assign w_round = r_frame_open ? r_round_en : cfg_round_en;

  assign w_x    = {s_tdata[pDATA_WIDTH-1], s_tdata};
  assign w_rnd  = (w_round && (w_shift != 5'd0)) ? (TW'(1) << (w_shift - 5'd1)) : '0;
  assign w_t    = w_x + w_rnd;
  assign w_y    = w_t >>> w_shift;
  assign w_hi   = (w_y > L_MAX);
  assign w_lo   = (w_y < L_MIN);
  assign w_clip = w_hi || w_lo;
  assign w_q    = w_hi ? SAT_MAX : (w_lo ? SAT_MIN : w_y[pOUT_WIDTH-1:0]);

  assign w_push = w_accept && (r_half || s_tlast);

  always_comb begin
    w_entry = '0;
    w_entry.last = s_tlast;
    if (r_half) begin
      w_entry.data = {w_q, r_low};
      w_entry.keep = KEEP_FULL;
    end else begin
      w_entry.data = {{pOUT_WIDTH{1'b0}}, w_q};
      w_entry.keep = KEEP_LOW;
    end
  end

  fir_out_fifo #(
    .pDEPTH (pFIFO_DEPTH),
    .pCNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (axis_clk),
    .i_srst  (axis_rst),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_rdy_en     <= 1'b0;
      r_frame_open <= 1'b0;
      r_shift      <= '0;
      r_round_en   <= 1'b0;
      r_half       <= 1'b0;
      r_low        <= '0;
      r_sat_cnt    <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        if (!r_frame_open) begin
          r_shift    <= cfg_shift;
          r_round_en <= cfg_round_en;
        end
        r_frame_open <= !s_tlast;
        if (!r_half && !s_tlast) begin
          r_low  <= w_q;
          r_half <= 1'b1;
        end else begin
          r_half <= 1'b0;
        end
      end
      // A clear coinciding with a clip leaves exactly that one clip counted.
      if (sat_clr) begin
        r_sat_cnt <= {15'd0, w_accept && w_clip};
      end else if (w_accept && w_clip && (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
      if (w_pop && w_head.last) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign m_tvalid  = (w_fifo_count != '0);
  assign m_tdata   = m_tvalid ? w_head.data : '0;
  assign m_tkeep   = m_tvalid ? w_head.keep : '0;
  assign m_tlast   = m_tvalid && w_head.last;
  assign sat_cnt   = r_sat_cnt;
  assign frame_cnt = r_frame_cnt;
  assign busy      = r_frame_open || r_half || (w_fifo_count != '0);

endmodule

// File: tb/tb_fir_out_pack.sv
// Randomised and directed bench for fir_out_pack against a list-based packing model.
module tb_fir_out_pack;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata  = '0;
  logic        s_tlast  = 1'b0;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_round_en = 1'b0;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_cnt;
  logic [15:0] frame_cnt;
  logic        busy;

  fir_out_pack dut (
    .axis_clk     (axis_clk),
    .axis_rst     (axis_rst),
    .s_tvalid     (s_tvalid),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tvalid     (m_tvalid),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .cfg_shift    (cfg_shift),
    .cfg_round_en (cfg_round_en),
    .sat_clr      (sat_clr),
    .sat_cnt      (sat_cnt),
    .frame_cnt    (frame_cnt),
    .busy         (busy)
  );

  initial forever #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  logic [31:0] frame_q[$];
  bit          m_open = 0;
  bit          m_half = 0;
  int          m_sh = 0;
  bit          m_rnd = 0;
  logic [15:0] m_low = '0;
  logic [15:0] m_sat = '0;
  logic [15:0] frame_exp = '0;
  int          popped = 0;
  int          cyc = 0;
  bit          hold_low = 1;
  bit          rand_stall = 0;
  bit          bp_on = 0;
  int          bp_base = 0;
  bit          prev_stall = 0;
  logic [36:0] prev_word = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requantise as a plain integer: add rounding offset, divide by 2^sh toward -inf, clip.
  function automatic logic [15:0] requant(input logic [31:0] d, input int sh, input bit rnd,
                                          output bit clip);
    longint x, t, y;
    x = longint'(signed'(d));
    t = x + ((rnd && sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
    y = t >>> sh;
    clip = (y > 32767) || (y < -32768);
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    return y[15:0];
  endfunction

  task automatic model_accept(input logic [31:0] d, input bit last, input bit clr);
    bit          clip;
    logic [15:0] y;
    exp_t        e;
    if (!m_open) begin
      m_sh  = int'(cfg_shift);
      m_rnd = cfg_round_en;
    end
    y = requant(d, m_sh, m_rnd, clip);
    if (clr) m_sat = clip ? 16'd1 : 16'd0;
    else if (clip && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
    if (m_half) begin
      e.d = {y, m_low}; e.k = 4'hF; e.l = last;
      exp_q.push_back(e);
      m_half = 0;
    end else if (last) begin
      e.d = {16'h0, y}; e.k = 4'h3; e.l = 1'b1;
      exp_q.push_back(e);
    end else begin
      m_low  = y;
      m_half = 1;
    end
    m_open = !last;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input bit clr);
    int waited = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last; sat_clr = clr;
    while (!s_tready) begin
      @(negedge axis_clk);
      waited++;
      if (waited > 1000) begin
        chk("tready_timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0; s_tlast = 1'b0; sat_clr = 1'b0;
        return;
      end
    end
    @(negedge axis_clk);
    model_accept(d, last, clr);
    s_tvalid = 1'b0; s_tlast = 1'b0; sat_clr = 1'b0;
  endtask

  // Config is scrambled after the first beat; the DUT must keep the latched values.
  task automatic send_frame(input int sh, input bit rnd);
    cfg_shift = 5'(sh); cfg_round_en = rnd;
    foreach (frame_q[i]) begin
      send_beat(frame_q[i], i == frame_q.size() - 1, 1'b0);
      if (i == 0) begin
        cfg_shift = 5'($urandom); cfg_round_en = 1'($urandom);
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 2000) begin
      @(negedge axis_clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge axis_clk);
    axis_rst = 1'b1;
    exp_q.delete();
    m_open = 0; m_half = 0; m_sat = '0; frame_exp = '0;
    repeat (2) @(negedge axis_clk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_word",   64'({m_tlast, m_tkeep, m_tdata}), 64'd0);
    chk("rst_sat_cnt",  64'(sat_cnt), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_busy",     64'(busy), 64'd0);
    axis_rst = 1'b0;
    @(negedge axis_clk);
    chk("post_rst_s_tready", 64'(s_tready), 64'd1);
  endtask

  // Output side: owns m_tready, checks each pop and the hold rule while stalled.
  always @(negedge axis_clk) begin
    bit   rdy;
    exp_t e;
    #2;
    cyc++;
    if (axis_rst) begin
      prev_stall = 0;
      m_tready   = 1'b0;
    end else begin
      rdy = !hold_low;
      if (bp_on && (cyc - bp_base) >= 10 && (cyc - bp_base) <= 30) rdy = 0;
      if (rand_stall && $urandom_range(0, 3) == 0) rdy = 0;
      if (bp_on && (cyc - bp_base) == 30) chk("bp_tready_low", 64'(s_tready), 64'd0);
      if (prev_stall) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_word", 64'({m_tlast, m_tkeep, m_tdata}), 64'(prev_word));
      end
      if (m_tvalid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(m_tdata), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          $display("word %0d: data=%h keep=%h last=%b", popped, m_tdata, m_tkeep, m_tlast);
          chk("word_data", 64'(m_tdata), 64'(e.d));
          chk("word_keep", 64'(m_tkeep), 64'(e.k));
          chk("word_last", 64'(m_tlast), 64'(e.l));
          if (e.l) frame_exp = frame_exp + 16'd1;
          popped++;
        end
      end
      prev_stall = m_tvalid && !rdy;
      prev_word  = {m_tlast, m_tkeep, m_tdata};
      m_tready   = rdy;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    hold_low = 0;

    // Pair frame
    frame_q = '{32'd100, -32'sd200};
    send_frame(0, 0);
    chk("pair_latency_valid", 64'(m_tvalid), 64'd1);
    chk("pair_word", 64'(m_tdata), 64'hFF380064);
    wait_drain();
    chk("pair_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);

    // Odd frame
    frame_q = '{32'd1, 32'd2, 32'd3};
    send_frame(0, 0);
    wait_drain();
    chk("odd_frame_cnt", 64'(frame_cnt), 64'(frame_exp));

    // Saturation and clear
    frame_q = '{32'd40000, -32'sd40000};
    send_frame(0, 0);
    chk("sat_word", 64'(m_tdata), 64'h80007FFF);
    wait_drain();
    chk("sat_cnt_two", 64'(sat_cnt), 64'd2);
    @(negedge axis_clk); sat_clr = 1'b1;
    @(negedge axis_clk); sat_clr = 1'b0; m_sat = '0;
    chk("sat_cnt_clr", 64'(sat_cnt), 64'd0);
    cfg_shift = 5'd0; cfg_round_en = 1'b0;
    send_beat(32'd40000, 1'b1, 1'b1);
    chk("sat_clr_coincident", 64'(sat_cnt), 64'd1);
    wait_drain();

    // Rounding
    frame_q = '{32'd5, -32'sd5};
    send_frame(1, 1);
    chk("round_on_word", 64'(m_tdata), 64'hFFFE0003);
    wait_drain();
    send_frame(1, 0);
    chk("round_off_word", 64'(m_tdata), 64'hFFFD0002);
    wait_drain();

    // Back-pressure on a 600-sample ramp
    frame_q.delete();
    for (int i = 0; i < 600; i++) frame_q.push_back(32'(i));
    popped  = 0;
    bp_base = cyc;
    bp_on   = 1;
    send_frame(0, 0);
    wait_drain();
    bp_on = 0;
    chk("bp_word_count", 64'(popped), 64'd300);
    chk("sat_cnt_model", 64'(sat_cnt), 64'(m_sat));

    // Randomised frames with random stalls, shifts and occasional clears
    rand_stall = 1;
    for (int f = 0; f < 25; f++) begin
      int len;
      int sh;
      len = $urandom_range(1, 9);
      sh  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 31);
      cfg_shift = 5'(sh); cfg_round_en = 1'($urandom);
      for (int i = 0; i < len; i++) begin
        logic [31:0] d;
        case ($urandom_range(0, 2))
          0:       d = 32'($urandom_range(0, 4000)) - 32'd2000;
          1:       d = 32'($urandom_range(0, 140000)) - 32'd70000;
          default: d = $urandom;
        endcase
        send_beat(d, i == len - 1, $urandom_range(0, 7) == 0);
        if (i == 0) begin
          cfg_shift = 5'($urandom); cfg_round_en = 1'($urandom);
        end
      end
    end
    wait_drain();
    rand_stall = 0;
    chk("rand_frame_cnt", 64'(frame_cnt), 64'(frame_exp));
    chk("rand_sat_cnt", 64'(sat_cnt), 64'(m_sat));

    // Reset mid-frame: the queued partial frame must vanish
    hold_low = 1;
    cfg_shift = 5'd3; cfg_round_en = 1'b1;
    send_beat(32'd10, 1'b0, 1'b0);
    send_beat(32'd20, 1'b0, 1'b0);
    send_beat(32'd30, 1'b0, 1'b0);
    chk("midframe_busy", 64'(busy), 64'd1);
    do_reset();
    hold_low = 0;
    repeat (3) @(negedge axis_clk);
    chk("midframe_no_output", 64'(m_tvalid), 64'd0);
    frame_q = '{32'd7, 32'd8};
    send_frame(0, 0);
    chk("after_rst_word", 64'(m_tdata), 64'h00080007);
    wait_drain();
    chk("after_rst_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_out_pack.md
Name: fir_out_pack

Overview:
- Downstream stage of the FIR engine. Consumes the FIR's 32-bit AXI-Stream result (sm_*).
- Requantises each result to 16 bits: arithmetic right shift, optional round-half-up, saturation.
- Packs result pairs into 32-bit AXI-Stream words for the DMA/BRAM writer that follows.
- Preserves frame boundaries (tlast) and keeps saturation and frame statistics.

Parameters:
- pDATA_WIDTH, 32, input sample width (FIR sm_tdata width).
- pOUT_WIDTH, 16, requantised sample width; two samples per output word.
- pFIFO_DEPTH, 2, output word buffer depth; minimum 2 for full throughput.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_rst  in  1  synchronous, active-high reset.
- s_tvalid  in  1  input sample valid (from FIR sm_tvalid).
- s_tdata  in  32  signed input sample.
- s_tlast  in  1  last sample of frame.
- s_tready  out  1  input accept.
- m_tvalid  out  1  output word valid.
- m_tdata  out  32  packed word: [15:0] older sample, [31:16] newer sample.
- m_tkeep  out  4  byte enables: 4'hF full word, 4'h3 lower half only.
- m_tlast  out  1  word contains the frame's last sample.
- m_tready  in  1  downstream accept.
- cfg_shift  in  5  right-shift amount, 0..31.
- cfg_round_en  in  1  add 2^(shift-1) before the shift when shift>0.
- sat_clr  in  1  one-cycle pulse; clears sat_cnt.
- sat_cnt  out  16  count of clipped samples; sticks at 0xFFFF.
- frame_cnt  out  16  count of completed output frames; wraps.
- busy  out  1  frame open, half-word pending, or FIFO non-empty.

Behaviour:
- Reset values: s_tready=0 during reset, 1 in the first cycle after; m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, sat_cnt=0, frame_cnt=0, busy=0. Reset mid-frame discards the pending half-word, FIFO contents and the latched config; no partial word is emitted.
- Accept rule: accept = s_tvalid & s_tready. s_tready = (fifo_count < pFIFO_DEPTH), driven from registers only; no combinational path from m_tready.
- Config latch: cfg_shift and cfg_round_en are latched on the first accepted beat of a frame (frame_open=0) and held until the tlast beat. Changes mid-frame are ignored.
- Requant (combinational, 33-bit signed):
  - t = sext(x) + (round_en && shift>0 ? 1<<(shift-1) : 0)
  - y = t >>> shift
  - Clip y to [-32768, 32767]. Each clipped accepted sample increments sat_cnt.
- Pack state: half_pending (0/1) and a 16-bit low register.
  - Accept with half_pending=0 and s_tlast=0: store low, half_pending=1. No push.
  - Accept with half_pending=1: push {y, low}, keep F, last=s_tlast; half_pending=0.
  - Accept with half_pending=0 and s_tlast=1: push {16'h0, y}, keep 3, last=1.
- Latency: the accept that completes a word gives m_tvalid on the next cycle when the FIFO was empty. Sustains 1 sample/cycle in and 1 word per 2 cycles out.
- Output: m_tvalid = fifo_count!=0; m_tdata, m_tkeep and m_tlast come from the FIFO head. Pop on m_tvalid & m_tready. A simultaneous push and pop in the same cycle leaves fifo_count unchanged.
- Hold rule: while m_tvalid=1 and m_tready=0, m_tdata, m_tkeep and m_tlast must not change.
- frame_cnt increments on each popped word with m_tlast=1.
- sat_clr in the same cycle as a saturation event: sat_cnt becomes 1.

Decomposition:
- Package fir_stream_pkg holds:
  - pDATA_WIDTH/pOUT_WIDTH constants
  - SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000
  - KEEP_FULL=4'hF, KEEP_LOW=4'h3
  - a packed typedef for the FIFO entry {last, keep[3:0], data[31:0]}
- One sub-module: fir_out_fifo, a synchronous FIFO of pFIFO_DEPTH entries with registered count, used as the output buffer. Requant and pack logic stay in the top module.

Test Plan:
- Pair frame: shift=0; inputs 100, -200(tlast); m_tready=1 -> one word 0xFF380064, keep F, tlast=1; frame_cnt=1.
- Odd frame: inputs 1, 2, 3(tlast) -> 0x00020001 keep F tlast=0, then 0x00000003 keep 3 tlast=1.
- Saturation: inputs 40000, -40000(tlast), shift=0 -> 0x80007FFF; sat_cnt=2; sat_clr then 0; sat_clr coincident with a clip gives 1.
- Rounding: shift=1; round_en=1 on inputs 5, -5 -> 3, -2 (0xFFFE0003); round_en=0 -> 2, -3 (0xFFFD0002).
- Back-pressure: continuous 600-sample ramp, m_tready=0 for cycles 10..30 -> s_tready drops once 2 words are queued; all 300 words in order, data held stable while stalled, last word tlast=1.
- Reset mid-frame: assert axis_rst after 3 of 6 samples -> no output for the partial frame; the following 2-sample frame packs correctly with frame_cnt=1.
